// File: rtl/alu_seq.sv
// alu_seq: multi-cycle W-bit execution unit with a start/done handshake.
// Single-step ops finish on the accepting edge. Iterative shifts/rotates and
// the shift-add multiply run one step per clock in RUN. Result registers
// change only on a completing edge or on reset.
module alu_seq #(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic         sc_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rslt,
  output logic [W-1:0] rslt_hi,
  output logic         sc_o,
  output logic         notequal,
  output logic         lessthan,
  output logic         zero
);

  localparam logic [2:0] OP_PAR = 3'b000;
  localparam logic [2:0] OP_SHL = 3'b001;
  localparam logic [2:0] OP_SHR = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ADD = 3'b111;

  typedef enum logic {IDLE, RUN} state_e;

  // One shift-add multiply step: conditionally add the multiplicand into the
  // upper half, then shift the whole product/multiplier register right.
  function automatic logic [2*W-1:0] mul_step(input logic [2*W-1:0] p,
                                              input logic [W-1:0]   m);
    logic [W:0] s;
    s = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, m} : {(W+1){1'b0}});
    return {s, p[W-1:1]};
  endfunction

  state_e         state, state_n;
  logic [SHW-1:0] cnt, cnt_n;
  logic [2:0]     op_r, op_n;
  logic [W-1:0]   a_r, a_n, m_r, m_n;
  logic           sc_r, sc_n, fill_r, fill_n;
  logic [2*W-1:0] p_r, p_n;

  logic           done_n, sco_n, ne_n, lt_n, z_n;
  logic [W-1:0]   rslt_n, hi_n;

  // Step source: live inputs on the accepting edge, working registers in RUN.
  logic [2:0]     src_op;
  logic [W-1:0]   src_a, src_m;
  logic           src_fill;
  logic [2*W-1:0] src_p, p_step;
  logic [W-1:0]   sh_a;
  logic           sh_sc;
  logic [SHW-1:0] n;
  logic [W:0]     add_sum;

  // Completion candidates
  logic           fin, f_sc, f_ne, f_lt;
  logic [W-1:0]   f_r, f_hi;

  assign busy = (state == RUN);
  assign n    = inB[SHW-1:0];

  // Select step operands and compute one shift/rotate/multiply step
  always_comb begin
    src_op   = (state == IDLE) ? op    : op_r;
    src_a    = (state == IDLE) ? inA   : a_r;
    src_fill = (state == IDLE) ? sc_in : fill_r;
    src_m    = (state == IDLE) ? inA   : m_r;
    src_p    = (state == IDLE) ? {{W{1'b0}}, inB} : p_r;
    p_step   = mul_step(src_p, src_m);
    add_sum  = {1'b0, inA} + {1'b0, inB} + {{W{1'b0}}, sc_in};
    sh_a     = src_a;
    sh_sc    = 1'b0;
    case (src_op)
      OP_SHL:  {sh_sc, sh_a} = {src_a, src_fill};
      OP_SHR:  {sh_a, sh_sc} = {src_fill, src_a};
      OP_ROL:  begin
        sh_a  = {src_a[W-2:0], src_a[W-1]};
        sh_sc = src_a[W-1];
      end
      default: ;
    endcase
  end

  // Next-state, working registers and completing-edge outputs
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_r;
    a_n     = a_r;
    sc_n    = sc_r;
    fill_n  = fill_r;
    p_n     = p_r;
    m_n     = m_r;
    fin     = 1'b0;
    f_r     = '0;
    f_hi    = '0;
    f_sc    = 1'b0;
    f_ne    = 1'b0;
    f_lt    = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        op_n   = op;
        fill_n = sc_in;
        m_n    = inA;
        a_n    = sh_a;
        sc_n   = sh_sc;
        p_n    = p_step;
        case (op)
          OP_PAR: begin fin = 1'b1; f_r = {{(W-1){1'b0}}, ^inA}; end
          OP_CMP: begin
            fin  = 1'b1;
            f_r  = inA - inB;
            f_ne = (inA != inB);
            f_lt = (inA < inB);
          end
          OP_AND: begin fin = 1'b1; f_r = inA & inB; end
          OP_ADD: begin fin = 1'b1; {f_sc, f_r} = add_sum; end
          OP_MUL: begin state_n = RUN; cnt_n = SHW'(W-1); end
          default: begin
            // SHL/SHR/ROL: zero amount passes inA through with no carry out
            if (n == '0) begin
              fin = 1'b1; f_r = inA;
            end else if (n == SHW'(1)) begin
              fin = 1'b1; f_r = sh_a; f_sc = sh_sc;
            end else begin
              state_n = RUN; cnt_n = n - SHW'(1);
            end
          end
        endcase
      end
      RUN: begin
        a_n   = sh_a;
        sc_n  = sh_sc;
        p_n   = p_step;
        cnt_n = cnt - SHW'(1);
        if (cnt == SHW'(1)) begin
          fin     = 1'b1;
          state_n = IDLE;
          if (op_r == OP_MUL) {f_hi, f_r} = p_step;
          else begin f_r = sh_a; f_sc = sh_sc; end
        end
      end
    endcase
    done_n = fin;
    rslt_n = fin ? f_r  : rslt;
    hi_n   = fin ? f_hi : rslt_hi;
    sco_n  = fin ? f_sc : sc_o;
    ne_n   = fin ? f_ne : notequal;
    lt_n   = fin ? f_lt : lessthan;
    z_n    = fin ? ((f_r == '0) && (f_hi == '0)) : zero;
  end

  // State, working and result registers; reset wins over start
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_r     <= '0;
      a_r      <= '0;
      sc_r     <= 1'b0;
      fill_r   <= 1'b0;
      p_r      <= '0;
      m_r      <= '0;
      done     <= 1'b0;
      rslt     <= '0;
      rslt_hi  <= '0;
      sc_o     <= 1'b0;
      notequal <= 1'b0;
      lessthan <= 1'b0;
      zero     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      op_r     <= op_n;
      a_r      <= a_n;
      sc_r     <= sc_n;
      fill_r   <= fill_n;
      p_r      <= p_n;
      m_r      <= m_n;
      done     <= done_n;
      rslt     <= rslt_n;
      rslt_hi  <= hi_n;
      sc_o     <= sco_n;
      notequal <= ne_n;
      lessthan <= lt_n;
      zero     <= z_n;
    end
  end

endmodule
